// File: rtl/mips_bus_arb_if.sv
// rtl/mips_bus_arb_if.sv - core-side request ports and external memory bus of the MIPS bus arbiter
interface mips_bus_arb_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        i_err;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        d_err;
  logic        m_req;
  logic        m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_ack;
  logic        stall;

  // master: the core ports plus the memory fabric; slave: the arbiter itself
  modport master (
    output i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, m_rdata, m_ack,
    input  i_rdata, i_ack, i_err, d_rdata, d_ack, d_err,
    input  m_req, m_we, m_be, m_addr, m_wdata, stall
  );

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, m_rdata, m_ack,
    output i_rdata, i_ack, i_err, d_rdata, d_ack, d_err,
    output m_req, m_we, m_be, m_addr, m_wdata, stall
  );
endinterface

// File: rtl/mips_bus_arb.sv
// rtl/mips_bus_arb.sv - single-bus arbiter between MIPS I fetch and load/store ports
module mips_bus_arb #(
  parameter int unsigned D_BURST = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset_n,
  mips_bus_arb_if.slave     bus
);

  typedef enum logic [1:0] {IDLE, IBUS, DBUS} state_t;

  localparam logic [3:0] BURST_MAX = 4'(D_BURST);
  localparam logic [7:0] TMO_MAX   = 8'(TIMEOUT);

  state_t      state_q, state_d;
  logic        m_req_q, m_req_d;
  logic        m_we_q, m_we_d;
  logic [3:0]  m_be_q, m_be_d;
  logic [31:0] m_addr_q, m_addr_d;
  logic [31:0] m_wdata_q, m_wdata_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        i_ack_q, i_ack_d;
  logic        i_err_q, i_err_d;
  logic        d_ack_q, d_ack_d;
  logic        d_err_q, d_err_d;
  logic [3:0]  burst_q, burst_d;
  logic [7:0]  tmo_q, tmo_d;

  logic i_elig, d_elig;

  // A port is not eligible on its own completion cycle, so a held req cannot double-grant
  assign i_elig = bus.i_req & ~i_ack_q & ~i_err_q;
  assign d_elig = bus.d_req & ~d_ack_q & ~d_err_q;

  always_comb begin
    state_d   = state_q;
    m_req_d   = m_req_q;
    m_we_d    = m_we_q;
    m_be_d    = m_be_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_ack_d   = 1'b0;
    i_err_d   = 1'b0;
    d_ack_d   = 1'b0;
    d_err_d   = 1'b0;
    burst_d   = burst_q;
    tmo_d     = tmo_q;

    case (state_q)
      IDLE: begin
        tmo_d = '0;
        if (d_elig && !(i_elig && burst_q == BURST_MAX)) begin
          state_d   = DBUS;
          m_req_d   = 1'b1;
          m_we_d    = bus.d_we;
          m_be_d    = bus.d_be;
          m_addr_d  = bus.d_addr;
          m_wdata_d = bus.d_wdata;
          // D only wins a contested slot below BURST_MAX, so the increment cannot overshoot
          burst_d   = i_elig ? burst_q + 4'd1 : 4'd0;
        end else if (i_elig) begin
          state_d   = IBUS;
          m_req_d   = 1'b1;
          m_we_d    = 1'b0;
          m_be_d    = 4'hF;
          m_addr_d  = bus.i_addr;
          m_wdata_d = '0;
          burst_d   = 4'd0;
        end
      end

      IBUS, DBUS: begin
        if (bus.m_ack) begin
          state_d = IDLE;
          m_req_d = 1'b0;
          tmo_d   = '0;
          if (state_q == IBUS) begin
            i_rdata_d = bus.m_rdata;
            i_ack_d   = 1'b1;
          end else begin
            d_rdata_d = bus.m_rdata;
            d_ack_d   = 1'b1;
          end
        end else if (tmo_q == TMO_MAX) begin
          state_d = IDLE;
          m_req_d = 1'b0;
          tmo_d   = '0;
          if (state_q == IBUS) begin
            i_rdata_d = '0;
            i_err_d   = 1'b1;
          end else begin
            d_rdata_d = '0;
            d_err_d   = 1'b1;
          end
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_be_q    <= '0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_ack_q   <= 1'b0;
      i_err_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      d_err_q   <= 1'b0;
      burst_q   <= '0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_be_q    <= m_be_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_ack_q   <= i_ack_d;
      i_err_q   <= i_err_d;
      d_ack_q   <= d_ack_d;
      d_err_q   <= d_err_d;
      burst_q   <= burst_d;
      tmo_q     <= tmo_d;
    end
  end

  assign bus.m_req   = m_req_q;
  assign bus.m_we    = m_we_q;
  assign bus.m_be    = m_be_q;
  assign bus.m_addr  = m_addr_q;
  assign bus.m_wdata = m_wdata_q;
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_rdata = d_rdata_q;
  assign bus.i_ack   = i_ack_q;
  assign bus.i_err   = i_err_q;
  assign bus.d_ack   = d_ack_q;
  assign bus.d_err   = d_err_q;
  assign bus.stall   = (bus.i_req & ~i_ack_q & ~i_err_q) | (bus.d_req & ~d_ack_q & ~d_err_q);

endmodule

// File: tb/tb_mips_bus_arb.sv
// tb/tb_mips_bus_arb.sv - directed self-checking bench for mips_bus_arb
module tb_mips_bus_arb;

  localparam int unsigned TB_BURST = 4;
  localparam int unsigned TB_TMO   = 10;

  logic clock;
  logic reset_n;
  int   vectors;
  int   miscompares;

  mips_bus_arb_if bus ();

  mips_bus_arb #(.D_BURST(TB_BURST), .TIMEOUT(TB_TMO)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    bus.i_req   = 1'b0;
    bus.i_addr  = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_be    = '0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    bus.m_rdata = '0;
    bus.m_ack   = 1'b0;

    repeat (2) @(posedge clock);
    #1;
    chk("rst_m_req", bus.m_req, 0);
    chk("rst_m_addr", bus.m_addr, 0);
    chk("rst_m_be", bus.m_be, 0);
    chk("rst_acks", {bus.i_ack, bus.i_err, bus.d_ack, bus.d_err}, 0);
    chk("rst_stall", bus.stall, 0);
    @(negedge clock);
    reset_n = 1'b1;

    // Single fetch, memory acks on the third bus cycle
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h0000_0100;
    #1;
    chk("f_stall_req", bus.stall, 1);
    tick();
    chk("f_m_req", bus.m_req, 1);
    chk("f_m_addr", bus.m_addr, 32'h100);
    chk("f_m_be", bus.m_be, 4'hF);
    chk("f_m_we", bus.m_we, 0);
    tick();
    tick();
    chk("f_wait_ack", bus.i_ack, 0);
    chk("f_wait_stall", bus.stall, 1);
    bus.m_ack   = 1'b1;
    bus.m_rdata = 32'h2402_0005;
    tick();
    chk("f_i_ack", bus.i_ack, 1);
    chk("f_i_rdata", bus.i_rdata, 32'h2402_0005);
    chk("f_m_req_drop", bus.m_req, 0);
    chk("f_stall_done", bus.stall, 0);
    bus.i_req = 1'b0;
    bus.m_ack = 1'b0;
    tick();
    chk("f_ack_pulse", bus.i_ack, 0);

    // Store priority over a simultaneous fetch
    bus.i_req   = 1'b1;
    bus.i_addr  = 32'h0000_0104;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_be    = 4'b0011;
    bus.d_addr  = 32'h0000_2000;
    bus.d_wdata = 32'hDEAD_BEEF;
    tick();
    chk("s_m_addr", bus.m_addr, 32'h2000);
    chk("s_m_we", bus.m_we, 1);
    chk("s_m_be", bus.m_be, 4'b0011);
    chk("s_m_wdata", bus.m_wdata, 32'hDEAD_BEEF);
    bus.m_ack   = 1'b1;
    bus.m_rdata = 32'h1111_2222;
    tick();
    chk("s_d_ack", bus.d_ack, 1);
    chk("s_d_rdata", bus.d_rdata, 32'h1111_2222);
    chk("s_i_quiet", bus.i_ack, 0);
    bus.m_ack = 1'b0;
    tick();
    chk("s_i_grant", bus.m_req, 1);
    chk("s_i_addr", bus.m_addr, 32'h104);
    chk("s_i_we", bus.m_we, 0);
    chk("s_d_pulse", bus.d_ack, 0);
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.m_ack   = 1'b1;
    bus.m_rdata = 32'h0000_0033;
    tick();
    chk("s_i_ack", bus.i_ack, 1);
    chk("s_i_rdata", bus.i_rdata, 32'h33);
    bus.i_req = 1'b0;
    bus.m_ack = 1'b0;
    tick();

    // Fairness: I contends for each slot; D wins four, then I is forced through
    bus.d_be    = 4'hF;
    bus.i_addr  = 32'h0000_0400;
    bus.m_rdata = 32'hA5A5_A5A5;
    for (int r = 0; r < 4; r++) begin
      bus.d_req  = 1'b1;
      bus.i_req  = 1'b1;
      bus.d_addr = 32'h3000 + 32'(4 * r);
      tick();
      chk("fair_d_grant", bus.m_addr, 32'h3000 + 32'(4 * r));
      bus.i_req = 1'b0;
      bus.m_ack = 1'b1;
      tick();
      chk("fair_d_ack", bus.d_ack, 1);
      bus.d_req = 1'b0;
      bus.m_ack = 1'b0;
      tick();
      chk("fair_idle", bus.m_req, 0);
    end
    bus.d_req  = 1'b1;
    bus.i_req  = 1'b1;
    bus.d_addr = 32'h3010;
    tick();
    chk("fair_i_forced", bus.m_addr, 32'h400);
    bus.m_ack = 1'b1;
    tick();
    chk("fair_i_ack", bus.i_ack, 1);
    bus.i_req = 1'b0;
    bus.m_ack = 1'b0;
    tick();
    chk("fair_d5_grant", bus.m_addr, 32'h3010);
    chk("fair_d5_req", bus.m_req, 1);
    bus.m_ack = 1'b1;
    tick();
    chk("fair_d5_ack", bus.d_ack, 1);
    bus.d_req = 1'b0;
    bus.m_ack = 1'b0;
    tick();
    bus.d_req  = 1'b1;
    bus.d_addr = 32'h3014;
    tick();
    chk("fair_d6_grant", bus.m_addr, 32'h3014);
    bus.m_ack = 1'b1;
    tick();
    chk("fair_d6_rdata", bus.d_rdata, 32'hA5A5_A5A5);
    bus.d_req = 1'b0;
    bus.m_ack = 1'b0;
    tick();

    // Timeout: err lands TIMEOUT+1 cycles after m_req rises
    bus.d_req  = 1'b1;
    bus.d_addr = 32'h5000;
    tick();
    chk("t_m_req", bus.m_req, 1);
    for (int c = 1; c <= int'(TB_TMO); c++) begin
      tick();
      chk("t_hold", {bus.m_req, bus.d_err}, 2'b10);
    end
    tick();
    chk("t_m_req_drop", bus.m_req, 0);
    chk("t_d_err", bus.d_err, 1);
    chk("t_no_ack", bus.d_ack, 0);
    chk("t_d_rdata", bus.d_rdata, 0);
    bus.d_req = 1'b0;
    tick();
    chk("t_err_pulse", bus.d_err, 0);

    // Ack on the timeout cycle wins; held req gives exactly one transaction per ack
    bus.d_req  = 1'b1;
    bus.d_addr = 32'h5004;
    tick();
    for (int c = 1; c <= int'(TB_TMO); c++) tick();
    bus.m_ack   = 1'b1;
    bus.m_rdata = 32'h0000_55AA;
    tick();
    chk("r_ack_wins", {bus.d_ack, bus.d_err}, 2'b10);
    chk("r_d_rdata", bus.d_rdata, 32'h55AA);
    bus.m_ack = 1'b0;
    tick();
    chk("r_no_double", bus.m_req, 0);
    chk("r_ack_pulse", bus.d_ack, 0);
    tick();
    chk("r_regrant", bus.m_req, 1);
    bus.m_ack = 1'b1;
    tick();
    chk("r_second_ack", bus.d_ack, 1);
    bus.d_req = 1'b0;
    bus.m_ack = 1'b0;
    tick();

    // Async reset while D owns the bus
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'h6000;
    bus.d_wdata = 32'h0000_1234;
    bus.i_req   = 1'b1;
    bus.i_addr  = 32'h0000_0800;
    tick();
    chk("a_m_req", bus.m_req, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("a_m_req_low", bus.m_req, 0);
    chk("a_m_addr", bus.m_addr, 0);
    chk("a_m_wdata", bus.m_wdata, 0);
    chk("a_rdata", {bus.i_rdata, bus.d_rdata}, 0);
    chk("a_flags", {bus.m_we, bus.i_ack, bus.i_err, bus.d_ack, bus.d_err}, 0);
    bus.d_req = 1'b0;
    bus.d_we  = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    chk("a_i_grant", bus.m_req, 1);
    chk("a_i_addr", bus.m_addr, 32'h800);
    bus.m_ack   = 1'b1;
    bus.m_rdata = 32'h0BAD_F00D;
    tick();
    chk("a_i_ack", bus.i_ack, 1);
    chk("a_i_rdata", bus.i_rdata, 32'h0BAD_F00D);
    bus.i_req = 1'b0;
    bus.m_ack = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
